// File: rtl/pulse_sched_pkg.sv
// Shared state encoding, widths and default parameters for pulse_scheduler.
package pulse_sched_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int WW_DEFAULT   = 4;
    localparam int CW_DEFAULT   = 4;
    localparam int GAP_DEFAULT  = 2;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_HIGH = 3'd1,
        ST_LOW  = 3'd2,
        ST_DONE = 3'd3,
        ST_GAP  = 3'd4
    } state_e;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last winner and wraps.
module rr_arbiter
    import pulse_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // Requesters above the last winner take precedence over those at or below it.
        for (int j = 0; j < NREQ; j++) begin
            if (!valid_o && req_i[j] && (j > int'(last_i))) begin
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
                valid_o    = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!valid_o && req_i[j] && (j <= int'(last_i))) begin
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Round-robin scheduler sharing one pulse-train generator among NREQ requesters.
// Optional guard interval between bursts is enabled by defining PULSE_SCHED_GAP_EN.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int WW   = WW_DEFAULT,
    parameter int CW   = CW_DEFAULT,
    parameter int GAP  = GAP_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] req_count,
    input  logic [WW-1:0]      high_len,
    input  logic [WW-1:0]      low_len,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               signal,
    output logic               busy
);

    localparam int IW = idx_width(NREQ);

    if (NREQ < 2 || NREQ > 8 || GAP < 0) begin : g_bad_param
        $error("pulse_scheduler: NREQ must be 2..8 and GAP non-negative");
    end

`ifdef PULSE_SCHED_GAP_EN
    localparam bit GAP_ON = (GAP > 0);
    localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
    logic [GW-1:0] gap_q;
`endif

    state_e          state_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] done_q;
    logic            signal_q;
    logic            busy_q;
    logic [IW-1:0]   last_q;
    logic [CW-1:0]   rem_q;
    logic [WW-1:0]   phase_q;
    logic [WW-1:0]   high_q;
    logic [WW-1:0]   low_q;

    logic [NREQ-1:0] win_onehot;
    logic [IW-1:0]   win_idx;
    logic            win_valid;
    logic [CW-1:0]   win_count_d;
    logic [WW-1:0]   high_eff_d;
    logic [WW-1:0]   low_eff_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (win_onehot),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_comb begin
        win_count_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_onehot[i]) begin
                win_count_d = req_count[i*CW +: CW];
            end
        end
        // A zero phase length would stall the down-counter, so it is stretched to one cycle.
        high_eff_d = (high_len == '0) ? WW'(1) : high_len;
        low_eff_d  = (low_len == '0) ? WW'(1) : low_len;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= IW'(NREQ - 1);
            rem_q    <= '0;
            phase_q  <= '0;
            high_q   <= '0;
            low_q    <= '0;
`ifdef PULSE_SCHED_GAP_EN
            gap_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        grant_q <= win_onehot;
                        last_q  <= win_idx;
                        high_q  <= high_eff_d;
                        low_q   <= low_eff_d;
                        rem_q   <= win_count_d;
                        busy_q  <= 1'b1;
                        if (win_count_d != '0) begin
                            state_q  <= ST_HIGH;
                            signal_q <= 1'b1;
                            phase_q  <= high_eff_d - WW'(1);
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= win_onehot;
                        end
                    end
                end
                ST_HIGH: begin
                    if (phase_q == '0) begin
                        state_q  <= ST_LOW;
                        signal_q <= 1'b0;
                        phase_q  <= low_q - WW'(1);
                    end else begin
                        phase_q <= phase_q - WW'(1);
                    end
                end
                ST_LOW: begin
                    if (phase_q == '0) begin
                        if (rem_q == CW'(1)) begin
                            state_q <= ST_DONE;
                            done_q  <= grant_q;
                            rem_q   <= '0;
                        end else begin
                            state_q  <= ST_HIGH;
                            rem_q    <= rem_q - CW'(1);
                            signal_q <= 1'b1;
                            phase_q  <= high_q - WW'(1);
                        end
                    end else begin
                        phase_q <= phase_q - WW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= '0;
                    grant_q <= '0;
`ifdef PULSE_SCHED_GAP_EN
                    if (GAP_ON) begin
                        state_q <= ST_GAP;
                        gap_q   <= GW'(GAP - 1);
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
`endif
                end
`ifdef PULSE_SCHED_GAP_EN
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
`endif
                default: begin
                    state_q  <= ST_IDLE;
                    grant_q  <= '0;
                    done_q   <= '0;
                    signal_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign signal = signal_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler: expected bursts are queued at stimulus time and
// checked cycle by cycle by a negedge monitor.
module tb_pulse_scheduler;

    localparam int NREQ = 4;
    localparam int WW   = 4;
    localparam int CW   = 4;
    localparam int GAP  = 2;
`ifdef PULSE_SCHED_GAP_EN
    localparam int GAP_EXP = GAP;
`else
    localparam int GAP_EXP = 0;
`endif

    logic               clock;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] req_count;
    logic [WW-1:0]      high_len;
    logic [WW-1:0]      low_len;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               signal;
    logic               busy;

    pulse_scheduler #(
        .NREQ (NREQ),
        .WW   (WW),
        .CW   (CW),
        .GAP  (GAP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_count (req_count),
        .high_len  (high_len),
        .low_len   (low_len),
        .grant     (grant),
        .done      (done),
        .signal    (signal),
        .busy      (busy)
    );

    typedef struct {
        int owner;
        int h;
        int l;
        int count;
        int lat_ref;
        bit spacing_chk;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   n_started = 0;
    int   n_done    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic exp_signal(input exp_t e, input int t);
        int per;
        per = e.h + e.l;
        if (t >= e.count * per) return 1'b0;
        return (t % per) < e.h;
    endfunction

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Monitor: one active burst at a time, compared against the head of the queue.
    exp_t cur;
    bit   active        = 1'b0;
    bit   just_done     = 1'b0;
    int   t             = 0;
    int   exp_len       = 0;
    int   last_done_cyc = -100;

    always @(negedge clock) begin
        if (reset) begin
            active    = 1'b0;
            just_done = 1'b0;
            check("reset_outputs", 32'({grant, done, signal, busy}), 32'd0);
        end else begin
            if (just_done) begin
                check("grant_after_done", 32'(grant), 32'd0);
                check("done_after_done", 32'(done), 32'd0);
                just_done = 1'b0;
            end else if (!active && grant != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    t      = 0;
                    n_started++;
                    if (cur.lat_ref >= 0) check("grant_latency", cyc - cur.lat_ref, 32'd1);
                    if (cur.spacing_chk) check("burst_spacing", cyc - last_done_cyc, 2 + GAP_EXP);
                end
            end
            if (active) begin
                exp_len = cur.count * (cur.h + cur.l);
                check("grant", 32'(grant), 1 << cur.owner);
                check("busy", 32'(busy), 32'd1);
                check("signal", 32'(signal), 32'(exp_signal(cur, t)));
                check("done", 32'(done), (t == exp_len) ? (1 << cur.owner) : 0);
                if (done != '0 || t > exp_len) begin
                    check("burst_len", t + 1, exp_len + 1);
                    active        = 1'b0;
                    just_done     = 1'b1;
                    last_done_cyc = cyc;
                    n_done++;
                end else begin
                    t++;
                end
            end else if (grant == '0) begin
                check("idle_outputs", 32'({done, signal}), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_count(input int idx, input int c);
        req_count[idx*CW +: CW] = CW'(c);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (n_done < target && n < budget) begin
            tick();
            n++;
        end
        check("bursts_completed", n_done, target);
    endtask

    task automatic wait_started(input int target, input int budget);
        int n;
        n = 0;
        while (n_started < target && n < budget) begin
            tick();
            n++;
        end
        check("bursts_started", n_started, target);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
    endtask

    // One requester asks for a single burst; inputs are scrambled after grant.
    task automatic run_single(input int idx, input int count, input int h, input int l);
        int target;
        repeat (4) tick();
        target   = n_done + 1;
        req      = '0;
        req[idx] = 1'b1;
        set_count(idx, count);
        high_len = WW'(h);
        low_len  = WW'(l);
        exp_q.push_back('{owner: idx, h: eff(h), l: eff(l), count: count,
                          lat_ref: cyc, spacing_chk: 1'b0});
        tick();
        req       = '0;
        high_len  = ~high_len;
        low_len   = WW'($urandom);
        req_count = (NREQ*CW)'($urandom);
        wait_done(target, count * (eff(h) + eff(l)) + 20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int order [5];
        int s0;
        int d0;

        reset     = 1'b1;
        req       = '0;
        req_count = '0;
        high_len  = '0;
        low_len   = '0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;

        // Quiet after reset with no requests.
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_quiet", 32'({grant, done, signal, busy}), 32'd0);
        end

        // Four 3-high/3-low pulses, grant held 25 cycles.
        run_single(0, 4, 3, 3);
        // Zero phase lengths behave as one cycle.
        run_single(1, 2, 0, 0);
        // Zero count: grant and done together, no pulse.
        run_single(2, 0, 5, 5);
        for (int i = 0; i < 3; i++) begin
            run_single(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
        end
        check("queue_drained_singles", exp_q.size(), 32'd0);

        // All four requesting continuously from a fresh reset.
        do_reset();
        repeat (2) tick();
        order = '{0, 1, 2, 3, 0};
        s0 = n_started;
        d0 = n_done;
        req_count = {NREQ{CW'(1)}};
        high_len  = WW'(1);
        low_len   = WW'(1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{owner: order[i], h: 1, l: 1, count: 1,
                              lat_ref: (i == 0) ? cyc : -1, spacing_chk: (i != 0)});
        end
        req = '1;
        wait_started(s0 + 5, 100);
        req = '0;
        wait_done(d0 + 5, 50);
        check("queue_drained_rr", exp_q.size(), 32'd0);

        // Reset in the middle of a count=5 burst.
        repeat (4) tick();
        s0 = n_started;
        d0 = n_done;
        req = 4'b0001;
        set_count(0, 5);
        high_len = WW'(4);
        low_len  = WW'(2);
        exp_q.push_back('{owner: 0, h: 4, l: 2, count: 5, lat_ref: cyc, spacing_chk: 1'b0});
        tick();
        req = '0;
        wait_started(s0 + 1, 10);
        check("pre_abort_signal", 32'(signal), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_signal", 32'(signal), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        check("no_done_on_abort", n_done, d0);

        // After reset req[0] must beat req[1] again.
        tick();
        req = 4'b0011;
        set_count(0, 1);
        set_count(1, 1);
        high_len = WW'(1);
        low_len  = WW'(1);
        exp_q.push_back('{owner: 0, h: 1, l: 1, count: 1, lat_ref: cyc, spacing_chk: 1'b0});
        tick();
        req = '0;
        wait_done(d0 + 1, 30);

        repeat (5) tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Round-robin scheduler that shares one programmable pulse-train generator among NREQ requesters. Each requester asks for a burst of N pulses; the scheduler grants one requester at a time, drives the shared `signal` output with the programmed high/low widths, and reports completion. It sits between the free-running `clock` source and the blocks that consume multi-pulse waveforms, replacing per-consumer fixed pulse generators.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WW, 4, width of high/low phase length fields
- CW, 4, width of per-requester pulse count
- GAP, 2, guard cycles between bursts (used only with PULSE_SCHED_GAP_EN)

Ports:
- clock  in  1  single system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  NREQ  request level per requester
- req_count  in  NREQ*CW  pulse count for requester i at bits [i*CW +: CW]
- high_len  in  WW  high phase length in cycles, sampled at grant
- low_len  in  WW  low phase length in cycles, sampled at grant
- grant  out  NREQ  one-hot owner of the generator, held for the whole burst
- done  out  NREQ  one-cycle completion pulse for the owning requester
- signal  out  1  shared pulse-train output
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, HIGH, LOW, DONE (+ GAP when configured).
- IDLE: if any `req` bit set, select winner round-robin; register grant, count, high_len, low_len; go HIGH (count>0) or DONE (count=0). No request: stay IDLE.
- Round-robin: search starts at last_granted+1 mod NREQ; after reset last_granted = NREQ-1, so req[0] has first priority.
- HIGH: `signal`=1 for H cycles, then LOW. LOW: `signal`=0 for L cycles; then decrement remaining count; nonzero -> HIGH, zero -> DONE.
- H = high_len, L = low_len; a value of 0 is treated as 1. Phase counters are WW bits, count down, no wrap.
- DONE: one cycle; `done[owner]`=1, grant still asserted; next state IDLE (or GAP).
- `req` changes during a burst are ignored; burst always completes. A requester still holding `req` after its `done` is a new request, arbitrated normally (others first).
- high_len/low_len/req_count changes after grant have no effect on the current burst.

## Timing
- Reset values: grant=0, done=0, signal=0, busy=0, state IDLE, last_granted=NREQ-1. Async assertion forces these at once, including mid-burst; no `done` is issued for an aborted burst.
- Grant latency: req sampled high at edge k -> grant and signal=1 visible after edge k (registered outputs, one edge).
- Burst length: count*(H+L) cycles of HIGH/LOW, then 1 DONE cycle, then 1 IDLE cycle before the next HIGH. Back-to-back minimum idle low time between bursts: L + 2 cycles (without gap).
- `done` and `grant` deassert on the same edge leaving DONE.
- All outputs are registered; no combinational path from req to any output.

## Configuration
- PULSE_SCHED_GAP_EN defined: DONE -> GAP for GAP cycles (grant=0, signal=0, busy=1, requests not sampled), then IDLE. GAP=0 behaves as undefined macro.
- Undefined: DONE -> IDLE directly; no GAP state, GAP parameter unused.

## Structure
- Shared package/include pulse_sched_pkg: state encoding constants (IDLE, HIGH, LOW, DONE, GAP), state width, default parameter values.
- One sub-module: rr_arbiter (NREQ-wide request vector + last_granted -> one-hot winner, combinational); FSM, counters and output registers live in pulse_scheduler.

## Test plan
- Reset, no requests, 50 cycles -> grant=0, signal=0, busy=0 throughout.
- req[0], count=4, H=3, L=3 -> four 3-high/3-low pulses (24 cycles), done[0] one cycle after last low, grant=0001 for 25 cycles.
- req=1111 held, count=1 each, H=1, L=1 -> grants in order 0,1,2,3,0 with single-cycle done each; with PULSE_SCHED_GAP_EN, GAP=2 -> 2 extra idle cycles between bursts.
- high_len=0, low_len=0, count=2 -> treated as H=L=1: pattern 1,0,1,0 then done.
- req[2] with count=0 -> no high pulse, grant=0100 and done[2] on same cycle, one cycle after request.
- reset asserted mid-HIGH of a count=5 burst -> signal, grant, busy drop immediately; no done; after release req[0] wins first.
